// File: rtl/tmr_voter_scrub_pkg.sv
// tmr_voter_scrub_pkg: copy indices and the 2-of-3 bitwise voter shared by the TMR word.
package tmr_voter_scrub_pkg;
  localparam int COPY_A = 0;
  localparam int COPY_B = 1;
  localparam int COPY_C = 2;
  // Widest word the voter handles; callers zero-extend and truncate around it.
  localparam int MAX_W = 64;
  function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                            input logic [MAX_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/tmr_seu_counter.sv
// tmr_seu_counter: saturating SEU event counter with sticky flag; clr keeps a same-cycle event.
module tmr_seu_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_event,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_flag
);
  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;
  logic [CNT_W-1:0] w_inc;
  assign w_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= CNT_W'(i_event);
      r_flag <= i_event;
    end else if (i_event) begin
      r_cnt  <= w_inc;
      r_flag <= 1'b1;
    end
  end
  assign o_cnt  = r_cnt;
  assign o_flag = r_flag;
endmodule

// File: rtl/tmr_voter_scrub.sv
// tmr_voter_scrub: triplicated control word with bitwise majority vote, scrubbing and SEU accounting.
module tmr_voter_scrub
  import tmr_voter_scrub_pkg::*;
#(
  parameter int               WIDTH    = 3,
  parameter int               CNT_W    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               SCRUB_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       inj_sel,
  input  logic [WIDTH-1:0] inj_mask,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [2:0]       err_copy,
  output logic             seu_flag,
  output logic [CNT_W-1:0] seu_cnt
);
  logic [WIDTH-1:0] r_copy [3];
  logic             r_mism;
  logic [WIDTH-1:0] w_v;
  logic [WIDTH-1:0] w_nxt [3];
  logic             w_mism;
  logic             w_event;
  assign w_v = WIDTH'(maj3(MAX_W'(r_copy[COPY_A]), MAX_W'(r_copy[COPY_B]), MAX_W'(r_copy[COPY_C])));
  // Injection lands after load/scrub selection so it also corrupts a freshly loaded word.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_nxt[i]    = (load ? din : SCRUB_EN ? w_v : r_copy[i]) ^ (inj_sel[i] ? inj_mask : '0);
      err_copy[i] = |(r_copy[i] ^ w_v);
    end
  end
  assign w_mism  = |err_copy;
  assign w_event = w_mism & ~r_mism;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) r_copy[i] <= RST_VAL;
      r_mism <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) r_copy[i] <= w_nxt[i];
      r_mism <= w_mism;
    end
  end
  tmr_seu_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_event(w_event),
    .i_clr  (clr),
    .o_cnt  (seu_cnt),
    .o_flag (seu_flag)
  );
  assign q = w_v;
endmodule

// File: tb/tb_tmr_voter_scrub.sv
// tb_tmr_voter_scrub: directed and randomized checks of three tmr_voter_scrub configurations against a copy-level model.
module tb_tmr_voter_scrub;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load [3];
  logic       clr [3];
  logic [2:0] din [3];
  logic [2:0] inj_sel [3];
  logic [2:0] inj_mask [3];
  logic [2:0] q [3];
  logic [2:0] err [3];
  logic       flag [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  int tests = 0, fails = 0;
  // Model: dut0 scrub/CNT_W=8, dut1 no-scrub/CNT_W=8, dut2 scrub/CNT_W=2; all RST_VAL=010.
  localparam logic [2:0] RV = 3'b010;
  localparam bit SCR [3] = '{1'b1, 1'b0, 1'b1};
  localparam int CMAX [3] = '{255, 255, 3};
  logic [2:0] mcpy [3][3];
  bit mmq [3];
  bit mflag [3];
  int mcnt [3];

  always #5 clk = ~clk;

  tmr_voter_scrub #(.WIDTH(3), .CNT_W(8), .RST_VAL(RV), .SCRUB_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .load(load[0]), .din(din[0]), .inj_sel(inj_sel[0]), .inj_mask(inj_mask[0]),
    .clr(clr[0]), .q(q[0]), .err_copy(err[0]), .seu_flag(flag[0]), .seu_cnt(cnt0));
  tmr_voter_scrub #(.WIDTH(3), .CNT_W(8), .RST_VAL(RV), .SCRUB_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .load(load[1]), .din(din[1]), .inj_sel(inj_sel[1]), .inj_mask(inj_mask[1]),
    .clr(clr[1]), .q(q[1]), .err_copy(err[1]), .seu_flag(flag[1]), .seu_cnt(cnt1));
  tmr_voter_scrub #(.WIDTH(3), .CNT_W(2), .RST_VAL(RV), .SCRUB_EN(1'b1)) dut2 (
    .clk(clk), .rst(rst), .load(load[2]), .din(din[2]), .inj_sel(inj_sel[2]), .inj_mask(inj_mask[2]),
    .clr(clr[2]), .q(q[2]), .err_copy(err[2]), .seu_flag(flag[2]), .seu_cnt(cnt2));

  function automatic int ocnt(int k);
    return k == 0 ? int'(cnt0) : k == 1 ? int'(cnt1) : int'(cnt2);
  endfunction

  // Majority by counting how many copies hold a 1 in each bit position.
  function automatic logic [2:0] mvote(int k);
    logic [2:0] v;
    for (int b = 0; b < 3; b++) begin
      int n = 0;
      for (int i = 0; i < 3; i++) n += mcpy[k][i][b] ? 1 : 0;
      v[b] = n >= 2;
    end
    return v;
  endfunction

  function automatic logic [2:0] merr(int k);
    logic [2:0] e;
    for (int i = 0; i < 3; i++) e[i] = mcpy[k][i] != mvote(k);
    return e;
  endfunction

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      load[k] = 1'b0; clr[k] = 1'b0; din[k] = '0; inj_sel[k] = '0; inj_mask[k] = '0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) mcpy[k][i] = RV;
      mmq[k] = 0; mflag[k] = 0; mcnt[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [2:0] v = mvote(k);
      bit mism = merr(k) != 0;
      bit ev = mism && !mmq[k];
      for (int i = 0; i < 3; i++) begin
        logic [2:0] n = load[k] ? din[k] : SCR[k] ? v : mcpy[k][i];
        mcpy[k][i] = inj_sel[k][i] ? n ^ inj_mask[k] : n;
      end
      mmq[k] = mism;
      if (clr[k]) begin
        mcnt[k] = ev ? 1 : 0; mflag[k] = ev;
      end else if (ev) begin
        mcnt[k] = mcnt[k] < CMAX[k] ? mcnt[k] + 1 : mcnt[k]; mflag[k] = 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    tests++; if (q[0] !== 3'b010) begin fails++; $display("FAIL reset_q got %b want 010", q[0]); end
    tests++; if (err[0] !== 3'b000) begin fails++; $display("FAIL reset_err got %b want 000", err[0]); end
    tests++; if (cnt0 !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt0); end
    tests++; if (flag[0] !== 1'b0) begin fails++; $display("FAIL reset_flag got %b want 0", flag[0]); end
  endtask

  task automatic test_load();
    load[0] = 1'b1; din[0] = 3'b110;
    cycle();
    tests++; if (q[0] !== 3'b110) begin fails++; $display("FAIL load_q got %b want 110", q[0]); end
    tests++; if (err[0] !== 3'b000 || cnt0 !== 8'd0) begin
      fails++; $display("FAIL load_noevent got err=%b cnt=%0d want 000/0", err[0], cnt0); end
  endtask

  task automatic test_inject_scrub();
    inj_sel[0] = 3'b010; inj_mask[0] = 3'b001;
    cycle();
    tests++; if (err[0] !== 3'b010 || q[0] !== 3'b110) begin
      fails++; $display("FAIL inj_visible got err=%b q=%b want 010/110", err[0], q[0]); end
    cycle();
    tests++; if (err[0] !== 3'b000) begin fails++; $display("FAIL inj_scrubbed got %b want 000", err[0]); end
    tests++; if (cnt0 !== 8'd1 || flag[0] !== 1'b1) begin
      fails++; $display("FAIL inj_count got cnt=%0d flag=%b want 1/1", cnt0, flag[0]); end
  endtask

  task automatic test_no_scrub();
    load[1] = 1'b1; din[1] = 3'b110;
    cycle();
    inj_sel[1] = 3'b100; inj_mask[1] = 3'b100;
    cycle();
    tests++; if (err[1] !== 3'b100) begin fails++; $display("FAIL noscrub_err0 got %b want 100", err[1]); end
    for (int n = 0; n < 5; n++) begin
      cycle();
      tests++; if (err[1] !== 3'b100) begin fails++; $display("FAIL noscrub_hold%0d got %b want 100", n, err[1]); end
    end
    tests++; if (cnt1 !== 8'd1) begin fails++; $display("FAIL noscrub_once got %0d want 1", cnt1); end
    load[1] = 1'b1; din[1] = 3'b110;
    cycle();
    tests++; if (err[1] !== 3'b000 || cnt1 !== 8'd1) begin
      fails++; $display("FAIL noscrub_reload got err=%b cnt=%0d want 000/1", err[1], cnt1); end
  endtask

  task automatic test_saturate();
    for (int n = 1; n <= 4; n++) begin
      inj_sel[2] = 3'b001; inj_mask[2] = 3'b001;
      cycle();
      cycle();
      tests++; if (int'(cnt2) != (n < 3 ? n : 3)) begin
        fails++; $display("FAIL sat_cnt%0d got %0d want %0d", n, cnt2, n < 3 ? n : 3); end
    end
    inj_sel[2] = 3'b100; inj_mask[2] = 3'b010;
    cycle();
    clr[2] = 1'b1;
    cycle();
    tests++; if (cnt2 !== 2'd1 || flag[2] !== 1'b1) begin
      fails++; $display("FAIL clr_event got cnt=%0d flag=%b want 1/1", cnt2, flag[2]); end
    clr[2] = 1'b1;
    cycle();
    tests++; if (cnt2 !== 2'd0 || flag[2] !== 1'b0) begin
      fails++; $display("FAIL clr_plain got cnt=%0d flag=%b want 0/0", cnt2, flag[2]); end
  endtask

  task automatic test_back_to_back();
    load[0] = 1'b1; din[0] = 3'b101; inj_sel[0] = 3'b001; inj_mask[0] = 3'b001;
    cycle();
    tests++; if (q[0] !== 3'b101 || err[0] !== 3'b001) begin
      fails++; $display("FAIL loadinj got q=%b err=%b want 101/001", q[0], err[0]); end
    load[0] = 1'b1; din[0] = 3'b011;
    cycle();
    tests++; if (q[0] !== 3'b011 || err[0] !== 3'b000 || cnt0 !== 8'd2) begin
      fails++; $display("FAIL loadmism got q=%b err=%b cnt=%0d want 011/000/2", q[0], err[0], cnt0); end
  endtask

  task automatic test_double_reset();
    load[0] = 1'b1; din[0] = 3'b110;
    cycle();
    inj_sel[0] = 3'b011; inj_mask[0] = 3'b001;
    cycle();
    tests++; if (q[0] !== 3'b111 || err[0] !== 3'b100) begin
      fails++; $display("FAIL double_flip got q=%b err=%b want 111/100", q[0], err[0]); end
    cycle();
    tests++; if (cnt0 !== 8'd3 || err[0] !== 3'b000) begin
      fails++; $display("FAIL double_count got cnt=%0d err=%b want 3/000", cnt0, err[0]); end
    inj_sel[0] = 3'b111; inj_mask[0] = 3'b100;
    cycle();
    tests++; if (q[0] !== 3'b011 || err[0] !== 3'b000) begin
      fails++; $display("FAIL triple_silent got q=%b err=%b want 011/000", q[0], err[0]); end
    inj_sel[0] = 3'b001; inj_mask[0] = 3'b010;
    cycle();
    #2 rst = 1'b1;
    #1;
    tests++; if (q[0] !== 3'b010 || err[0] !== 3'b000 || cnt0 !== 8'd0 || flag[0] !== 1'b0) begin
      fails++; $display("FAIL async_rst got q=%b err=%b cnt=%0d flag=%b want 010/000/0/0", q[0], err[0], cnt0, flag[0]); end
    tests++; if (cnt1 !== 8'd0 || q[1] !== 3'b010) begin
      fails++; $display("FAIL async_rst1 got cnt=%0d q=%b want 0/010", cnt1, q[1]); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        load[k] = $urandom_range(3) == 0;
        din[k] = 3'($urandom);
        inj_sel[k] = 3'($urandom);
        inj_mask[k] = $urandom_range(2) == 0 ? 3'($urandom) : 3'b000;
        clr[k] = $urandom_range(15) == 0;
      end
      cycle();
      for (int k = 0; k < 3; k++) begin
        tests++; if (q[k] !== mvote(k) || err[k] !== merr(k)) begin
          fails++; $display("FAIL rnd_vote dut%0d cyc%0d got q=%b err=%b want %b/%b", k, n, q[k], err[k], mvote(k), merr(k)); end
        tests++; if (ocnt(k) != mcnt[k] || flag[k] !== mflag[k]) begin
          fails++; $display("FAIL rnd_seu dut%0d cyc%0d got cnt=%0d flag=%b want %0d/%b", k, n, ocnt(k), flag[k], mcnt[k], mflag[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_inject_scrub();
    test_no_scrub();
    test_saturate();
    test_back_to_back();
    test_double_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
